alu_arbiter: RTL

Round-robin arbiter and sequencer that shares the single 8-bit ALU (add, sub, and, or, xor, nor, plus zero/carry/overflow/negative flags) among several independent requesters, such as processor cores or DMA/test agents. It accepts one operation at a time and drives the registered operands to the ALU. It captures the ALU result and flags one cycle later and returns them to the winning requester with a one-cycle response strobe. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational ALU among NREQ requesters.
// Each accepted operation takes one grant cycle (IDLE->EXEC) and one response cycle (EXEC->IDLE).
module alu_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [3*NREQ-1:0]     i_req_op,
    input  logic [WIDTH*NREQ-1:0] i_req_a,
    input  logic [WIDTH*NREQ-1:0] i_req_b,
    output logic [NREQ-1:0]       o_gnt,
    output logic [2:0]            o_alu_op,
    output logic [WIDTH-1:0]      o_alu_a,
    output logic [WIDTH-1:0]      o_alu_b,
    input  logic [WIDTH-1:0]      i_alu_result,
    input  logic [3:0]            i_alu_flags,
    output logic [NREQ-1:0]       o_rsp_valid,
    output logic [WIDTH-1:0]      o_rsp_result,
    output logic [3:0]            o_rsp_flags,
    output logic                  o_busy
);

    localparam int PTRW = $clog2(NREQ);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [PTRW-1:0]   r_ptr;
    logic [PTRW-1:0]   r_winIdx;
    logic [PTRW-1:0]   w_winner;
    logic              w_found;
    logic              w_accept;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_rspValid;
    logic [2:0]        r_aluOp;
    logic [WIDTH-1:0]  r_aluA;
    logic [WIDTH-1:0]  r_aluB;
    logic [WIDTH-1:0]  r_rspResult;
    logic [3:0]        r_rspFlags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % NREQ]) begin
                w_found  = 1'b1;
                w_winner = PTRW'((int'(r_ptr) + i) % NREQ);
            end
        end
        w_accept    = (r_state == IDLE) && w_found;
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found) w_nextState = EXEC;
            EXEC:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == EXEC);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= PTRW'(NREQ - 1);
            r_winIdx    <= '0;
            r_gnt       <= '0;
            r_rspValid  <= '0;
            r_aluOp     <= '0;
            r_aluA      <= '0;
            r_aluB      <= '0;
            r_rspResult <= '0;
            r_rspFlags  <= '0;
        end else begin
            r_gnt      <= '0;
            r_rspValid <= '0;
            if (w_accept) begin
                r_aluOp  <= i_req_op[int'(w_winner)*3 +: 3];
                r_aluA   <= i_req_a[int'(w_winner)*WIDTH +: WIDTH];
                r_aluB   <= i_req_b[int'(w_winner)*WIDTH +: WIDTH];
                r_gnt    <= NREQ'(1) << w_winner;
                r_ptr    <= w_winner;
                r_winIdx <= w_winner;
            end
            // The ALU has settled on the registered operands by the end of EXEC.
            if (r_state == EXEC) begin
                r_rspResult <= i_alu_result;
                r_rspFlags  <= i_alu_flags;
                r_rspValid  <= NREQ'(1) << r_winIdx;
            end
        end
    end

    assign o_gnt        = r_gnt;
    assign o_rsp_valid  = r_rspValid;
    assign o_alu_op     = r_aluOp;
    assign o_alu_a      = r_aluA;
    assign o_alu_b      = r_aluB;
    assign o_rsp_result = r_rspResult;
    assign o_rsp_flags  = r_rspFlags;

endmodule
